rr_addr_encoder: RTL and testbench

- Sequential round-robin encoder: the inverse of the 3-to-8 row decoder in the memory array.
- Collects up to 8 one-per-row request lines, picks one fairly and presents its 3-bit address to the array under a valid/ready handshake.
- On handshake completion it returns a one-cycle one-hot acknowledge so the winning row can clear its request.
- Sits between the per-row request sources and the row decoder's addr input.

---
 rtl/rr_addr_encoder.sv | 117 +++++++++++
 tb/tb_rr_addr_encoder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_addr_encoder.sv
// Round-robin request encoder: picks one of N row requests fairly, presents its
// address under valid/ready, then pulses a one-hot acknowledge for the winner.
module rr_addr_encoder #(
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [AW-1:0] addr,
  output logic          valid,
  input  logic          ready,
  output logic [N-1:0]  ack,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t        state_r;
  logic [AW-1:0] ptr_r;
  logic [AW-1:0] addr_r;
  logic          valid_r;
  logic [N-1:0]  ack_r;
  logic          busy_r;

  // First set request found scanning circularly upward from p.
  function automatic logic [AW-1:0] rr_pick(input logic [N-1:0] r, input logic [AW-1:0] p);
    logic [AW-1:0] pick;
    logic          hit;
    int            idx;
    pick = '0;
    hit  = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(p) + i) % N;
      if (!hit && r[idx]) begin
        pick = AW'(idx);
        hit  = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [AW-1:0] a);
    return {{(N-1){1'b0}}, 1'b1} << a;
  endfunction

  // The winner becomes lowest priority; wrap explicitly so non-power-of-two N works.
  function automatic logic [AW-1:0] ptr_after(input logic [AW-1:0] a);
    logic [AW-1:0] nxt;
    if (a == AW'(N - 1)) begin
      nxt = '0;
    end else begin
      nxt = a + AW'(1);
    end
    return nxt;
  endfunction

  // Grant/acknowledge sequencer with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ptr_r   <= '0;
      addr_r  <= '0;
      valid_r <= 1'b0;
      ack_r   <= '0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ack_r <= '0;
          if (|req) begin
            addr_r  <= rr_pick(req, ptr_r);
            valid_r <= 1'b1;
            busy_r  <= 1'b1;
            state_r <= GRANT;
          end else begin
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        GRANT: begin
          // The grant is committed: req is not looked at until the next IDLE.
          if (valid_r && ready) begin
            valid_r <= 1'b0;
            ack_r   <= onehot(addr_r);
            ptr_r   <= ptr_after(addr_r);
            state_r <= ACK;
          end else begin
            valid_r <= 1'b1;
            ack_r   <= '0;
          end
        end
        ACK: begin
          ack_r   <= '0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          valid_r <= 1'b0;
          ack_r   <= '0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign addr  = addr_r;
  assign valid = valid_r;
  assign ack   = ack_r;
  assign busy  = busy_r;

endmodule

// File: tb/tb_rr_addr_encoder.sv
// Bench for rr_addr_encoder: directed literal scenarios plus randomized traffic
// compared every cycle against a phase-level behavioural model.
module tb_rr_addr_encoder;

  localparam int N  = 8;
  localparam int AW = 3;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [AW-1:0] addr;
  logic          valid;
  logic          ready;
  logic [N-1:0]  ack;
  logic          busy;

  int checks;
  int failures;

  rr_addr_encoder #(.N(N), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .addr  (addr),
    .valid (valid),
    .ready (ready),
    .ack   (ack),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = waiting, 1 = offering, 2 = acknowledging.
  int       m_phase;
  int       m_next;
  int       m_addr;
  bit       m_valid;
  bit [7:0] m_ack;
  bit       m_busy;

  function automatic int first_from(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  // Model advance on each edge; reset is immediate like the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_next <= 0; m_addr <= 0; m_valid <= 0; m_ack <= '0; m_busy <= 0;
    end else if (m_phase == 0) begin
      m_ack <= '0;
      if (req != '0) begin
        m_addr <= first_from(req, m_next);
        m_valid <= 1; m_busy <= 1; m_phase <= 1;
      end
    end else if (m_phase == 1) begin
      if (ready) begin
        m_valid <= 0;
        m_ack   <= 8'(1 << m_addr);
        m_next  <= (m_addr + 1) % N;
        m_phase <= 2;
      end
    end else begin
      m_ack <= '0; m_busy <= 0; m_phase <= 0;
    end
  end

  bit cmp_en;

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      chk("model_valid", int'(valid), int'(m_valid));
      chk("model_ack", int'(ack), int'(m_ack));
      chk("model_busy", int'(busy), int'(m_busy));
      if (m_valid) chk("model_addr", int'(addr), m_addr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", int'(valid), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_addr", int'(addr), 0);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0; failures = 0; cmp_en = 1'b0;
    req = '0; ready = 1'b0; rst_n = 1'b1;
    #2;
    do_reset();
    step();
    cmp_en = 1'b1;

    // Single request at row 2.
    req = 8'b0000_0100; ready = 1'b1;
    step();
    chk("t1_valid", int'(valid), 1);
    chk("t1_addr", int'(addr), 2);
    chk("t1_busy", int'(busy), 1);
    step();
    chk("t1_ack", int'(ack), 8'h04);
    chk("t1_valid_low", int'(valid), 0);
    req = '0;
    step();
    chk("t1_ack_clear", int'(ack), 0);
    chk("t1_busy_clear", int'(busy), 0);

    // Pointer now 3: search wraps to 0, then 2.
    req = 8'b0000_0101;
    step();
    chk("t3_first", int'(addr), 0);
    step(); step(); step();
    chk("t3_second", int'(addr), 2);
    chk("t3_valid", int'(valid), 1);
    req = '0;
    step(); step();

    // All rows requesting: strict rotation from 0, valid rising every 3 cycles.
    do_reset();
    req = 8'hFF; ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      chk("rr_valid", int'(valid), 1);
      chk("rr_addr", int'(addr), i % N);
      step();
      chk("rr_ack", int'(ack), 1 << (i % N));
      step();
      chk("rr_gap_valid", int'(valid), 0);
    end
    req = '0;
    step();

    // Stalled grant at row 5 with req churning and bit 5 dropping.
    req = 8'h20; ready = 1'b0;
    step();
    chk("t4_addr", int'(addr), 5);
    for (int i = 0; i < 6; i++) begin
      req = 8'($urandom_range(0, 255)) & 8'hDF;
      step();
      chk("t4_hold_addr", int'(addr), 5);
      chk("t4_hold_valid", int'(valid), 1);
      chk("t4_hold_ack", int'(ack), 0);
    end
    ready = 1'b1;
    step();
    chk("t4_ack", int'(ack), 8'h20);
    req = '0;
    step(); step();

    // Asynchronous reset in the middle of a grant.
    req = 8'h40; ready = 1'b0;
    step();
    chk("t5_addr", int'(addr), 6);
    chk("t5_valid", int'(valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", int'(valid), 0);
    chk("t5_async_ack", int'(ack), 0);
    chk("t5_async_busy", int'(busy), 0);
    step();
    rst_n = 1'b1;
    req = 8'b0100_0001; ready = 1'b1;
    step();
    chk("t5_ptr_reset", int'(addr), 0);
    req = '0;
    step(); step();

    // No requests: ready is irrelevant.
    for (int i = 0; i < 10; i++) begin
      ready = ~ready;
      step();
      chk("t6_valid", int'(valid), 0);
      chk("t6_ack", int'(ack), 0);
      chk("t6_busy", int'(busy), 0);
    end

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: req = '0;
        1: req = 8'(1 << $urandom_range(0, 7));
        default: req = 8'($urandom_range(0, 255));
      endcase
      ready = ($urandom_range(0, 2) != 0);
      step();
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
